// File: rtl/sseg_pkg.sv
// Shared definitions for the multiplexed 7-segment display path.
// Provides blank/dash segment patterns, the all-anodes-off code, the pattern
// type, the display source state type and a helper that builds the active-low
// one-hot anode code for a scan index.
package sseg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'b0111_1111;
   localparam logic [3:0] AN_OFF    = 4'b1111;

   typedef logic [7:0] sseg_pat_t;

   typedef enum logic [0:0] {
      S_BASE = 1'b0,
      S_MSG  = 1'b1
   } src_state_t;

   // Active-low one-hot anode code for scan index sel.
   function automatic logic [3:0] an_onehot_low(input logic [1:0] sel);
      logic [3:0] code;
      case (sel)
         2'd0:    code = 4'b1110;
         2'd1:    code = 4'b1101;
         2'd2:    code = 4'b1011;
         2'd3:    code = 4'b0111;
         default: code = AN_OFF;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// Digit scan timer for the multiplexed display.
// Counts REFRESH_DIV clock cycles per digit slot and advances the 2-bit scan
// index when a slot wraps. The first cycle of every slot is flagged so the
// caller can blank the anodes (dead time) and latch the next digit pattern.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous reset, active-low
//   digit_sel  out  current scan index 0..3 (registered)
//   slot_start out  high while the slot counter is 0 (dead-time cycle)
module sseg_scan_timer #(
   parameter int REFRESH_DIV = 100000,
   parameter int SLOT_W      = $clog2(REFRESH_DIV)
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [1:0] digit_sel,
   output logic       slot_start
);

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);

   logic [SLOT_W-1:0] slot_cnt_r;
   logic [1:0]        digit_sel_r;

   // Slot counter and scan index; the index steps once per full slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_cnt_r  <= {SLOT_W{1'b0}};
         digit_sel_r <= 2'd0;
      end else if (slot_cnt_r == SLOT_LAST) begin
         slot_cnt_r  <= {SLOT_W{1'b0}};
         digit_sel_r <= digit_sel_r + 2'd1;
      end else begin
         slot_cnt_r  <= slot_cnt_r + {{(SLOT_W-1){1'b0}}, 1'b1};
         digit_sel_r <= digit_sel_r;
      end
   end

   assign digit_sel  = digit_sel_r;
   assign slot_start = (slot_cnt_r == {SLOT_W{1'b0}});

endmodule

// File: rtl/sseg_display_scheduler.sv
// 4-digit multiplexed 7-segment display scheduler.
// Selects between a steady base display and a transient message that is held
// for MSG_HOLD cycles, scans one anode at a time with a one-cycle dead slot,
// and drives registered segment/anode pins.
// Ports:
//   clk              in   system clock
//   rst_n            in   synchronous reset, active-low
//   base_an0..3      in   base patterns {g..a,dp}, active-low, sampled at slot start
//   msg_an0..3       in   message patterns, captured when msg_valid is accepted
//   msg_valid        in   1-cycle request to show msg_an0..3 (always accepted)
//   msg_clear        in   abort the current message
//   blank            in   force all anodes off while high
//   seg              out  segment drive, active-low, registered
//   an               out  anode drive, active-low one-hot or 4'b1111, registered
//   digit_sel        out  current scan index 0..3, registered
//   msg_active       out  high while the message source is selected
module sseg_display_scheduler
   import sseg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int MSG_HOLD    = 200000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] base_an0,
   input  logic [7:0] base_an1,
   input  logic [7:0] base_an2,
   input  logic [7:0] base_an3,
   input  logic [7:0] msg_an0,
   input  logic [7:0] msg_an1,
   input  logic [7:0] msg_an2,
   input  logic [7:0] msg_an3,
   input  logic       msg_valid,
   input  logic       msg_clear,
   input  logic       blank,
   output logic [7:0] seg,
   output logic [3:0] an,
   output logic [1:0] digit_sel,
   output logic       msg_active
);

   localparam int HOLD_W = $clog2(MSG_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(MSG_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_ZERO   = {HOLD_W{1'b0}};
   localparam logic [HOLD_W-1:0] HOLD_ONE    = {{(HOLD_W-1){1'b0}}, 1'b1};

   src_state_t        state_r;
   src_state_t        state_s;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [HOLD_W-1:0] hold_cnt_s;
   logic              capture_s;
   sseg_pat_t         msg_buf_r [4];
   sseg_pat_t         src_pat_s;
   sseg_pat_t         pat_r;
   logic [7:0]        seg_r;
   logic [3:0]        an_r;
   logic [1:0]        digit_sel_s;
   logic              slot_start_s;

   sseg_scan_timer #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_scan_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .digit_sel  (digit_sel_s),
      .slot_start (slot_start_s)
   );

   // Source FSM next state: a new message always restarts the hold, and it
   // takes priority over a simultaneous clear.
   always_comb begin
      state_s    = state_r;
      hold_cnt_s = hold_cnt_r;
      capture_s  = 1'b0;
      case (state_r)
         S_BASE: begin
            if (msg_valid) begin
               capture_s  = 1'b1;
               hold_cnt_s = HOLD_RELOAD;
               state_s    = S_MSG;
            end else begin
               state_s    = S_BASE;
            end
         end
         S_MSG: begin
            if (msg_valid) begin
               capture_s  = 1'b1;
               hold_cnt_s = HOLD_RELOAD;
               state_s    = S_MSG;
            end else if (msg_clear) begin
               hold_cnt_s = HOLD_ZERO;
               state_s    = S_BASE;
            end else if (hold_cnt_r == HOLD_ZERO) begin
               state_s    = S_BASE;
            end else begin
               hold_cnt_s = hold_cnt_r - HOLD_ONE;
            end
         end
         default: begin
            hold_cnt_s = HOLD_ZERO;
            state_s    = S_BASE;
         end
      endcase
   end

   // Source FSM state, hold counter and message buffer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= S_BASE;
         hold_cnt_r <= HOLD_ZERO;
         for (int i = 0; i < 4; i++) begin
            msg_buf_r[i] <= SEG_BLANK;
         end
      end else begin
         state_r    <= state_s;
         hold_cnt_r <= hold_cnt_s;
         if (capture_s) begin
            msg_buf_r[0] <= msg_an0;
            msg_buf_r[1] <= msg_an1;
            msg_buf_r[2] <= msg_an2;
            msg_buf_r[3] <= msg_an3;
         end
      end
   end

   // Pattern for the digit being scanned, from the currently selected source.
   always_comb begin
      src_pat_s = SEG_BLANK;
      case (digit_sel_s)
         2'd0:    src_pat_s = (state_r == S_MSG) ? msg_buf_r[0] : base_an0;
         2'd1:    src_pat_s = (state_r == S_MSG) ? msg_buf_r[1] : base_an1;
         2'd2:    src_pat_s = (state_r == S_MSG) ? msg_buf_r[2] : base_an2;
         2'd3:    src_pat_s = (state_r == S_MSG) ? msg_buf_r[3] : base_an3;
         default: src_pat_s = SEG_BLANK;
      endcase
   end

   // Pin registers. The digit pattern (and thus the source choice) is latched
   // only in the dead cycle, so a lit digit never mixes sources or updates.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pat_r <= SEG_BLANK;
         seg_r <= SEG_BLANK;
         an_r  <= AN_OFF;
      end else begin
         if (slot_start_s) begin
            pat_r <= src_pat_s;
         end
         if (blank || slot_start_s) begin
            seg_r <= SEG_BLANK;
            an_r  <= AN_OFF;
         end else begin
            seg_r <= pat_r;
            an_r  <= an_onehot_low(digit_sel_s);
         end
      end
   end

   assign seg        = seg_r;
   assign an         = an_r;
   assign digit_sel  = digit_sel_s;
   assign msg_active = (state_r == S_MSG);

endmodule

// File: tb/tb_sseg_display_scheduler.sv
// Scoreboard bench for sseg_display_scheduler (REFRESH_DIV=4, MSG_HOLD=20).
// A reference model derives the expected pins from elapsed cycles since reset
// and the remaining message lifetime; a monitor compares them each cycle.
module tb_sseg_display_scheduler;

   localparam int DIV  = 4;
   localparam int HOLD = 20;

   typedef struct {
      logic [7:0] seg;
      logic [3:0] an;
      logic [1:0] dsel;
      logic       act;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] base_an0, base_an1, base_an2, base_an3;
   logic [7:0] msg_an0, msg_an1, msg_an2, msg_an3;
   logic       msg_valid, msg_clear, blank;
   logic [7:0] seg;
   logic [3:0] an;
   logic [1:0] digit_sel;
   logic       msg_active;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cycle  = 0;
   bit   model_ok = 1'b0;

   sseg_display_scheduler #(
      .REFRESH_DIV (DIV),
      .MSG_HOLD    (HOLD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .base_an0   (base_an0),
      .base_an1   (base_an1),
      .base_an2   (base_an2),
      .base_an3   (base_an3),
      .msg_an0    (msg_an0),
      .msg_an1    (msg_an1),
      .msg_an2    (msg_an2),
      .msg_an3    (msg_an3),
      .msg_valid  (msg_valid),
      .msg_clear  (msg_clear),
      .blank      (blank),
      .seg        (seg),
      .an         (an),
      .digit_sel  (digit_sel),
      .msg_active (msg_active)
   );

   always #5 clk = ~clk;

   // Reference model: elapsed cycles decide slot phase and digit; a message
   // lives for a number of remaining cycles.
   initial begin
      int         tick;
      int         msg_left;
      logic [7:0] mbuf [4];
      logic [7:0] bpat [4];
      logic [7:0] shown;
      int         phase, dig;
      exp_t       e;
      tick = 0;
      msg_left = 0;
      shown = 8'hFF;
      for (int i = 0; i < 4; i++) mbuf[i] = 8'hFF;
      forever begin
         @(posedge clk);
         cycle++;
         if (rst_n === 1'b0) begin
            tick = 0;
            msg_left = 0;
            shown = 8'hFF;
            for (int i = 0; i < 4; i++) mbuf[i] = 8'hFF;
            e.seg = 8'hFF; e.an = 4'b1111; e.dsel = 2'd0; e.act = 1'b0;
            model_ok = 1'b1;
            exp_q.push_back(e);
         end else if (model_ok) begin
            bpat[0] = base_an0; bpat[1] = base_an1;
            bpat[2] = base_an2; bpat[3] = base_an3;
            phase = tick % DIV;
            dig   = (tick / DIV) % 4;
            if (phase == 0) shown = (msg_left > 0) ? mbuf[dig] : bpat[dig];
            if (blank || phase == 0) begin
               e.an  = 4'b1111;
               e.seg = 8'hFF;
            end else begin
               e.an  = ~(4'b0001 << dig);
               e.seg = shown;
            end
            e.dsel = 2'((tick + 1) / DIV % 4);
            if (msg_valid) begin
               msg_left = HOLD;
               mbuf[0] = msg_an0; mbuf[1] = msg_an1;
               mbuf[2] = msg_an2; mbuf[3] = msg_an3;
            end else if (msg_clear) begin
               msg_left = 0;
            end else if (msg_left > 0) begin
               msg_left--;
            end
            e.act = (msg_left > 0);
            tick++;
            exp_q.push_back(e);
         end
      end
   end

   // Monitor: one expected entry per clock once the model is running.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 4;
            if (seg !== e.seg) begin
               errors++;
               $display("FAIL seg cycle=%0d got=%h exp=%h", cycle, seg, e.seg);
            end
            if (an !== e.an) begin
               errors++;
               $display("FAIL an cycle=%0d got=%b exp=%b", cycle, an, e.an);
            end
            if (digit_sel !== e.dsel) begin
               errors++;
               $display("FAIL digit_sel cycle=%0d got=%0d exp=%0d", cycle, digit_sel, e.dsel);
            end
            if (msg_active !== e.act) begin
               errors++;
               $display("FAIL msg_active cycle=%0d got=%b exp=%b", cycle, msg_active, e.act);
            end
         end else if (model_ok) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty cycle=%0d got=0 entries exp=1", cycle);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_msg(input logic [7:0] d0);
      msg_an0 = d0;
      msg_an1 = 8'($urandom);
      msg_an2 = 8'($urandom);
      msg_an3 = 8'($urandom);
   endtask

   task automatic pulse_valid();
      msg_valid = 1'b1;
      step(1);
      msg_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      base_an0 = 8'h81; base_an1 = 8'hF3; base_an2 = 8'h49; base_an3 = 8'h61;
      msg_an0 = 8'hFF; msg_an1 = 8'hFF; msg_an2 = 8'hFF; msg_an3 = 8'hFF;
      msg_valid = 1'b0; msg_clear = 1'b0; blank = 1'b0;
      step(3);
      rst_n = 1'b1;

      // Base scan, digit wrap.
      step(40);
      // Single message held for the full time.
      rand_msg(8'h7F);
      pulse_valid();
      step(30);
      // Restart of the hold mid-message.
      rand_msg(8'h7F);
      pulse_valid();
      step(10);
      rand_msg(8'($urandom));
      pulse_valid();
      step(25);
      // Clear and valid together, then a lone clear, then clear in base.
      rand_msg(8'($urandom));
      msg_valid = 1'b1; msg_clear = 1'b1;
      step(1);
      msg_valid = 1'b0; msg_clear = 1'b0;
      step(5);
      msg_clear = 1'b1;
      step(1);
      msg_clear = 1'b0;
      step(3);
      msg_clear = 1'b1;
      step(1);
      msg_clear = 1'b0;
      step(4);
      // Blank window while a message is counting.
      pulse_valid();
      step(2);
      blank = 1'b1;
      step(6);
      blank = 1'b0;
      step(12);
      // Reset in the middle of a message.
      rand_msg(8'($urandom));
      pulse_valid();
      step(7);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(20);

      // Randomised traffic.
      for (int c = 0; c < 1500; c++) begin
         msg_valid = ($urandom_range(0, 39) == 0);
         msg_clear = ($urandom_range(0, 49) == 0);
         rst_n     = ($urandom_range(0, 599) != 0);
         if ($urandom_range(0, 29) == 0) blank = ~blank;
         if ($urandom_range(0, 15) == 0) begin
            base_an0 = 8'($urandom); base_an1 = 8'($urandom);
            base_an2 = 8'($urandom); base_an3 = 8'($urandom);
         end
         if (msg_valid) rand_msg(8'($urandom));
         step(1);
      end
      msg_valid = 1'b0; msg_clear = 1'b0; blank = 1'b0; rst_n = 1'b1;
      step(4);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
